aes_ctr_pad: RTL and testbench
==============================

Name: aes_ctr_pad

Overview:
- AES-128 counter-mode keystream ("pad") generator.
- Encrypts the block {nonce, counter} under a fixed 128-bit key and returns the 128-bit ciphertext as a pad. The pad is XORed with data elsewhere in the datapath.
- Iterative core: one round per clock, one request in flight, valid/ready handshakes on both request and pad sides.

Parameters:
- KEY, 128'h0, AES-128 cipher key (FIPS-197 byte order, byte 0 = bits 127:120). Overridden per deployment.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- nonce  input  96  upper 96 bits of the input block.
- counter  input  32  lower 32 bits of the input block.
- req_val  input  1  request valid.
- req_rdy  output  1  core idle; can accept a request.
- pad  output  128  AES_KEY(nonce, counter) result.
- pad_val  output  1  pad valid.
- pad_rdy  input  1  consumer accepts pad.

Behaviour:
- Input block = {nonce, counter}: nonce in bits 127:32, counter in bits 31:0. Bit 127 is the MSB of state byte 0, column-major per FIPS-197.
- pad = AES-128 encryption of the block under KEY, standard FIPS-197, 10 rounds.
- Reset values: req_rdy=1, pad_val=0, pad=0, FSM in IDLE, round counter 0, state 0. Reset is asserted asynchronously; release is synchronous to clk.
- FSM states: IDLE, BUSY, DONE.
- IDLE: req_rdy=1, pad_val=0. On req_val&&req_rdy at a rising edge:
  - capture state = block XOR KEY (round-0 AddRoundKey);
  - load round key 0 = KEY; round=1; go to BUSY.
- BUSY: req_rdy=0. Each cycle, apply SubBytes, ShiftRows, MixColumns (omitted when round==10) and AddRoundKey with the next round key.
  - Round keys are expanded on the fly, one per cycle, using rcon[round].
  - After round 10 completes, go to DONE.
  - Fixed latency: pad_val rises exactly 10 cycles after the accepting edge.
- DONE: pad_val=1, pad stable and equal to the final state, req_rdy=0.
  - On pad_val&&pad_rdy: clear pad_val, go to IDLE. req_rdy is 1 the cycle after.
  - pad retains its value after handshake until the next result overwrites it.
- req_val held high after acceptance is ignored because req_rdy=0 while BUSY/DONE. nonce and counter are sampled only at the accepting edge; later changes have no effect.
- pad_rdy asserted early (IDLE/BUSY) has no effect. pad_rdy held high while DONE consumes the pad on the first DONE cycle.
- No back-to-back overlap: a new request is accepted no earlier than the cycle after pad consumption.
- rst in any state immediately aborts, discards the in-flight result and returns to reset values.
- The counter is not incremented internally; the caller supplies each counter value.

Decomposition:
- Package aes_pkg:
  - sbox function (256-entry lookup, combinational);
  - xtime / gf_mul2 function;
  - rcon constant array (01,02,04,08,10,20,40,80,1b,36);
  - state-name enum for IDLE/BUSY/DONE.
- Sub-module aes_round: combinational round (SubBytes, ShiftRows, optional MixColumns, AddRoundKey) with a last-round flag. The top instantiates it once plus key-schedule step logic.

Test Plan:
- Reset: assert rst mid-BUSY -> pad_val=0, req_rdy=1, pad=0 on release; a subsequent request completes normally.
- KEY=0, nonce=0, counter=0 -> pad=66e94bd4ef8a2c3b884cfa59ca342b2e, pad_val exactly 10 cycles after accept.
- KEY=000102030405060708090a0b0c0d0e0f, nonce=00112233445566778899aabb, counter=ccddeeff -> pad=69c4e0d86a7b0430d8cdb78070b4c55a.
- Handshake stress: hold req_val 2 extra cycles after accept and hold pad_rdy low for 5 cycles in DONE -> single result, pad stable throughout, req_rdy low until consumed.
- Back-to-back: three requests (counter 0, 1, deadbeef) with pad_rdy tied high -> three pads in order, each consumed on its first DONE cycle. Results match a software AES model.
- Input change after accept: modify nonce/counter during BUSY -> pad reflects the values captured at the accepting edge.

Source files
------------

// File: rtl/aes_ctr_pad_pkg.sv
// AES-128 shared definitions: S-box, GF(2^8) doubling, round constants, FSM states.
// Latency: none (pure types, constants and combinational functions).
// Backpressure: not applicable.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [3:0] LAST_ROUND = 4'd10;

  // Indexed by round number, so RCON[1] belongs to round 1.
  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  // Entry 0 sits in the most significant byte, so SBOX[b] is the forward S-box of b.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

  // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul2(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_ctr_pad_round.sv
// One AES encryption round: SubBytes, ShiftRows, MixColumns (skipped on last round), AddRoundKey.
// Latency: purely combinational.
// Backpressure: not applicable; the caller decides when to register the result.
module aes_round
  import aes_pkg::*;
(
  input  logic [127:0] state_i,
  input  logic [127:0] rk_i,
  input  logic         last_i,
  output logic [127:0] state_o
);

  // Byte 0 is bits 127:120; byte 4*c+r is row r of column c.
  logic [0:15][7:0] in_b;
  logic [0:15][7:0] sb;
  logic [0:15][7:0] sr;
  logic [0:15][7:0] mc;

  assign in_b = state_i;

  // Byte substitution, row rotation, column mixing and key addition in one cone.
  always_comb begin
    sb = '0;
    sr = '0;
    mc = '0;
    for (int i = 0; i < 16; i++) begin
      sb[i] = sbox(in_b[i]);
    end
    // Row r rotates left by r columns.
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[4*c+r] = sb[4*((c+r)%4)+r];
      end
    end
    // 3*a is written as gf_mul2(a) ^ a.
    for (int c = 0; c < 4; c++) begin
      mc[4*c]   = gf_mul2(sr[4*c]) ^ gf_mul2(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+1] = sr[4*c] ^ gf_mul2(sr[4*c+1]) ^ gf_mul2(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
      mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ gf_mul2(sr[4*c+2]) ^ gf_mul2(sr[4*c+3]) ^ sr[4*c+3];
      mc[4*c+3] = gf_mul2(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ gf_mul2(sr[4*c+3]);
    end
    state_o = (last_i ? sr : mc) ^ rk_i;
  end

endmodule

// File: rtl/aes_ctr_pad.sv
// AES-128 counter-mode pad generator: pad = AES_KEY({nonce, counter}), one round per clock.
// Latency: pad_val rises exactly 10 cycles after the accepting edge; one request in flight.
// Backpressure: pad held in DONE until pad_rdy; req_rdy stays low from accept until the pad is consumed.
module aes_ctr_pad
  import aes_pkg::*;
#(
  parameter logic [127:0] KEY = 128'h0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [95:0]  nonce,
  input  logic [31:0]  counter,
  input  logic         req_val,
  output logic         req_rdy,
  output logic [127:0] pad,
  output logic         pad_val,
  input  logic         pad_rdy
);

  fsm_e         fsm_q, fsm_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] state_q, state_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] pad_q, pad_d;
  logic         pad_val_q, pad_val_d;
  logic         req_rdy_q, req_rdy_d;

  logic [7:0]   rcon_b;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  sub_rot;
  logic [127:0] rk_next;
  logic [127:0] round_out;

  // Round constant for the key being derived this cycle; zero outside rounds 1..10.
  always_comb begin
    rcon_b = 8'h00;
    if (round_q >= 4'd1 && round_q <= LAST_ROUND) begin
      rcon_b = RCON[round_q];
    end
  end

  // On-the-fly key schedule: derive round key N from round key N-1.
  always_comb begin
    w0      = rk_q[127:96];
    w1      = rk_q[95:64];
    w2      = rk_q[63:32];
    w3      = rk_q[31:0];
    sub_rot = {sbox(w3[23:16]) ^ rcon_b, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    rk_next[127:96] = w0 ^ sub_rot;
    rk_next[95:64]  = w1 ^ w0 ^ sub_rot;
    rk_next[63:32]  = w2 ^ w1 ^ w0 ^ sub_rot;
    rk_next[31:0]   = w3 ^ w2 ^ w1 ^ w0 ^ sub_rot;
  end

  aes_round u_round (
    .state_i (state_q),
    .rk_i    (rk_next),
    .last_i  (round_q == LAST_ROUND),
    .state_o (round_out)
  );

  // Next-state logic for the IDLE -> BUSY -> DONE request cycle.
  always_comb begin
    fsm_d     = fsm_q;
    round_d   = round_q;
    state_d   = state_q;
    rk_d      = rk_q;
    pad_d     = pad_q;
    pad_val_d = pad_val_q;
    req_rdy_d = req_rdy_q;
    case (fsm_q)
      IDLE: begin
        if (req_val && req_rdy_q) begin
          state_d   = {nonce, counter} ^ KEY;
          rk_d      = KEY;
          round_d   = 4'd1;
          req_rdy_d = 1'b0;
          fsm_d     = BUSY;
        end
      end
      BUSY: begin
        state_d = round_out;
        rk_d    = rk_next;
        if (round_q == LAST_ROUND) begin
          pad_d     = round_out;
          pad_val_d = 1'b1;
          round_d   = 4'd0;
          fsm_d     = DONE;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (pad_rdy) begin
          pad_val_d = 1'b0;
          req_rdy_d = 1'b1;
          fsm_d     = IDLE;
        end
      end
      default: begin
        fsm_d     = IDLE;
        round_d   = 4'd0;
        pad_val_d = 1'b0;
        req_rdy_d = 1'b1;
      end
    endcase
  end

  // State registers; reset aborts any request and clears the held pad.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q     <= IDLE;
      round_q   <= 4'd0;
      state_q   <= '0;
      rk_q      <= '0;
      pad_q     <= '0;
      pad_val_q <= 1'b0;
      req_rdy_q <= 1'b1;
    end else begin
      fsm_q     <= fsm_d;
      round_q   <= round_d;
      state_q   <= state_d;
      rk_q      <= rk_d;
      pad_q     <= pad_d;
      pad_val_q <= pad_val_d;
      req_rdy_q <= req_rdy_d;
    end
  end

  assign req_rdy = req_rdy_q;
  assign pad     = pad_q;
  assign pad_val = pad_val_q;

endmodule

// File: tb/tb_aes_ctr_pad.sv
// Directed bench for aes_ctr_pad: two instances (all-zero key and the FIPS-197 example key).
// Latency: checks the fixed 10-cycle accept-to-pad_val timing.
// Backpressure: exercises held req_val, delayed pad_rdy and tied-high pad_rdy.
module tb_aes_ctr_pad;

  localparam logic [127:0] KEY1      = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ZERO_PAD  = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
  localparam logic [127:0] FIPS_PAD  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [95:0]  FIPS_NON  = 96'h00112233445566778899aabb;
  localparam logic [31:0]  FIPS_CTR  = 32'hccddeeff;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [95:0]  nonce = '0;
  logic [31:0]  counter = '0;
  logic         req_val0 = 1'b0, req_val1 = 1'b0;
  logic         pad_rdy = 1'b0;
  logic         req_rdy0, req_rdy1, pad_val0, pad_val1;
  logic [127:0] pad0, pad1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  aes_ctr_pad #(.KEY(128'h0)) dut0 (
    .clk(clk), .rst(rst), .nonce(nonce), .counter(counter), .req_val(req_val0),
    .req_rdy(req_rdy0), .pad(pad0), .pad_val(pad_val0), .pad_rdy(pad_rdy)
  );

  aes_ctr_pad #(.KEY(KEY1)) dut1 (
    .clk(clk), .rst(rst), .nonce(nonce), .counter(counter), .req_val(req_val1),
    .req_rdy(req_rdy1), .pad(pad1), .pad_val(pad_val1), .pad_rdy(pad_rdy)
  );

  // ---------------- reference AES (S-box derived from GF inverse + affine map) ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
    logic [7:0] r;
    r = (v << k) | (v >> (8 - k));
    return r;
  endfunction

  function automatic logic [7:0] sbox_m(input logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] base;
    logic [7:0] e;
    inv  = 8'h01;
    base = x;
    e    = 8'd254;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) inv = gmul(inv, base);
      base = gmul(base, base);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] aes_model(input logic [127:0] key, input logic [127:0] blk);
    logic [31:0]  w [44];
    logic [7:0]   st [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   rc;
    logic [31:0]  tmp;
    logic [127:0] res;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sbox_m(tmp[23:16]), sbox_m(tmp[15:8]), sbox_m(tmp[7:0]), sbox_m(tmp[31:24])} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        st[r][c] = blk[127-8*(4*c+r) -: 8] ^ w[c][31-8*r -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          t[r][c] = sbox_m(st[r][(c+r)%4]);
      for (int c = 0; c < 4; c++) begin
        if (rnd < 10) begin
          st[0][c] = gmul(t[0][c], 8'h02) ^ gmul(t[1][c], 8'h03) ^ t[2][c] ^ t[3][c];
          st[1][c] = t[0][c] ^ gmul(t[1][c], 8'h02) ^ gmul(t[2][c], 8'h03) ^ t[3][c];
          st[2][c] = t[0][c] ^ t[1][c] ^ gmul(t[2][c], 8'h02) ^ gmul(t[3][c], 8'h03);
          st[3][c] = gmul(t[0][c], 8'h03) ^ t[1][c] ^ t[2][c] ^ gmul(t[3][c], 8'h02);
        end else begin
          for (int r = 0; r < 4; r++) st[r][c] = t[r][c];
        end
        for (int r = 0; r < 4; r++) st[r][c] = st[r][c] ^ w[4*rnd+c][31-8*r -: 8];
      end
    end
    res = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        res[127-8*(4*c+r) -: 8] = st[r][c];
    return res;
  endfunction

  // ---------------- stimulus helpers (no checking inside) ----------------
  // Starts and ends at posedge+1; the edge in between is the accepting edge.
  task automatic do_accept(input bit sel, input logic [95:0] n, input logic [31:0] c);
    nonce   = n;
    counter = c;
    if (sel) req_val1 = 1'b1; else req_val0 = 1'b0 | 1'b1;
    @(posedge clk); #1;
    req_val0 = 1'b0;
    req_val1 = 1'b0;
  endtask

  // Counts cycles until pad_val is seen; returns 40 if it never rises.
  task automatic wait_pad(input bit sel, output int cyc);
    cyc = 0;
    while (((sel ? pad_val1 : pad_val0) !== 1'b1) && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic consume();
    pad_rdy = 1'b1;
    @(posedge clk); #1;
    pad_rdy = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_model();
    logic [127:0] m;
    m = aes_model(128'h0, 128'h0);
    checks++; if (m !== ZERO_PAD) begin errors++; $display("FAIL model_zero: got %h want %h", m, ZERO_PAD); end
    m = aes_model(KEY1, {FIPS_NON, FIPS_CTR});
    checks++; if (m !== FIPS_PAD) begin errors++; $display("FAIL model_fips: got %h want %h", m, FIPS_PAD); end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++; if (req_rdy0 !== 1'b1) begin errors++; $display("FAIL rst_req_rdy: got %b want 1", req_rdy0); end
    checks++; if (pad_val0 !== 1'b0) begin errors++; $display("FAIL rst_pad_val: got %b want 0", pad_val0); end
    checks++; if (pad0 !== 128'h0) begin errors++; $display("FAIL rst_pad: got %h want 0", pad0); end
    checks++; if (req_rdy1 !== 1'b1) begin errors++; $display("FAIL rst_req_rdy1: got %b want 1", req_rdy1); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero_vector();
    int cyc;
    checks++; if (req_rdy0 !== 1'b1) begin errors++; $display("FAIL zero_idle_rdy: got %b want 1", req_rdy0); end
    do_accept(1'b0, 96'h0, 32'h0);
    checks++; if (req_rdy0 !== 1'b0) begin errors++; $display("FAIL zero_busy_rdy: got %b want 0", req_rdy0); end
    wait_pad(1'b0, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL zero_latency: got %0d want 10", cyc); end
    checks++; if (pad0 !== ZERO_PAD) begin errors++; $display("FAIL zero_pad: got %h want %h", pad0, ZERO_PAD); end
    checks++; if (req_rdy0 !== 1'b0) begin errors++; $display("FAIL zero_done_rdy: got %b want 0", req_rdy0); end
    consume();
    checks++; if (pad_val0 !== 1'b0) begin errors++; $display("FAIL zero_consumed_val: got %b want 0", pad_val0); end
    checks++; if (req_rdy0 !== 1'b1) begin errors++; $display("FAIL zero_consumed_rdy: got %b want 1", req_rdy0); end
    checks++; if (pad0 !== ZERO_PAD) begin errors++; $display("FAIL zero_pad_retained: got %h want %h", pad0, ZERO_PAD); end
  endtask

  task automatic test_fips_vector();
    int cyc;
    do_accept(1'b1, FIPS_NON, FIPS_CTR);
    wait_pad(1'b1, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL fips_latency: got %0d want 10", cyc); end
    checks++; if (pad1 !== FIPS_PAD) begin errors++; $display("FAIL fips_pad: got %h want %h", pad1, FIPS_PAD); end
    consume();
  endtask

  task automatic test_reset_mid_busy();
    int cyc;
    do_accept(1'b0, 96'h0, 32'h1);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (pad_val0 !== 1'b0) begin errors++; $display("FAIL midrst_async_val: got %b want 0", pad_val0); end
    checks++; if (req_rdy0 !== 1'b1) begin errors++; $display("FAIL midrst_async_rdy: got %b want 1", req_rdy0); end
    checks++; if (pad0 !== 128'h0) begin errors++; $display("FAIL midrst_async_pad: got %h want 0", pad0); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    checks++; if (pad_val0 !== 1'b0) begin errors++; $display("FAIL midrst_rel_val: got %b want 0", pad_val0); end
    checks++; if (req_rdy0 !== 1'b1) begin errors++; $display("FAIL midrst_rel_rdy: got %b want 1", req_rdy0); end
    do_accept(1'b0, 96'h0, 32'h0);
    wait_pad(1'b0, cyc);
    checks++; if (cyc !== 10) begin errors++; $display("FAIL midrst_after_latency: got %0d want 10", cyc); end
    checks++; if (pad0 !== ZERO_PAD) begin errors++; $display("FAIL midrst_after_pad: got %h want %h", pad0, ZERO_PAD); end
    consume();
  endtask

  task automatic test_handshake_stress();
    int cyc;
    logic [127:0] exp;
    exp = aes_model(KEY1, {96'hcafef00d1234567800abcdef, 32'h00000005});
    nonce    = 96'hcafef00d1234567800abcdef;
    counter  = 32'h00000005;
    req_val1 = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 2; k++) begin
      checks++; if (req_rdy1 !== 1'b0) begin errors++; $display("FAIL hs_rdy_held%0d: got %b want 0", k, req_rdy1); end
      @(posedge clk); #1;
    end
    req_val1 = 1'b0;
    wait_pad(1'b1, cyc);
    checks++; if (cyc !== 8) begin errors++; $display("FAIL hs_latency: got %0d want 8", cyc); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (pad_val1 !== 1'b1) begin errors++; $display("FAIL hs_val_stall%0d: got %b want 1", k, pad_val1); end
      checks++; if (pad1 !== exp) begin errors++; $display("FAIL hs_pad_stall%0d: got %h want %h", k, pad1, exp); end
      checks++; if (req_rdy1 !== 1'b0) begin errors++; $display("FAIL hs_rdy_stall%0d: got %b want 0", k, req_rdy1); end
      @(posedge clk); #1;
    end
    consume();
    checks++; if (pad_val1 !== 1'b0) begin errors++; $display("FAIL hs_consumed_val: got %b want 0", pad_val1); end
    checks++; if (req_rdy1 !== 1'b1) begin errors++; $display("FAIL hs_consumed_rdy: got %b want 1", req_rdy1); end
    repeat (3) @(posedge clk);
    #1;
    checks++; if (pad_val1 !== 1'b0) begin errors++; $display("FAIL hs_single_result: got %b want 0", pad_val1); end
  endtask

  task automatic test_input_change();
    int cyc;
    logic [127:0] exp;
    exp = aes_model(KEY1, {96'h0102030405060708090a0b0c, 32'h11223344});
    do_accept(1'b1, 96'h0102030405060708090a0b0c, 32'h11223344);
    for (int k = 0; k < 5; k++) begin
      nonce   = {3{32'hfeedface ^ 32'(k)}};
      counter = 32'h99999999 + 32'(k);
      @(posedge clk); #1;
    end
    wait_pad(1'b1, cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL chg_latency: got %0d want 5", cyc); end
    checks++; if (pad1 !== exp) begin errors++; $display("FAIL chg_pad: got %h want %h", pad1, exp); end
    consume();
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [31:0]  ctrs [3];
    logic [127:0] exp;
    ctrs[0] = 32'h00000000;
    ctrs[1] = 32'h00000001;
    ctrs[2] = 32'hdeadbeef;
    pad_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = aes_model(KEY1, {96'habcdef0123456789a5a5a5a5, ctrs[i]});
      checks++; if (req_rdy1 !== 1'b1) begin errors++; $display("FAIL b2b_rdy%0d: got %b want 1", i, req_rdy1); end
      do_accept(1'b1, 96'habcdef0123456789a5a5a5a5, ctrs[i]);
      wait_pad(1'b1, cyc);
      checks++; if (cyc !== 10) begin errors++; $display("FAIL b2b_latency%0d: got %0d want 10", i, cyc); end
      checks++; if (pad1 !== exp) begin errors++; $display("FAIL b2b_pad%0d: got %h want %h", i, pad1, exp); end
      @(posedge clk); #1;
      checks++; if (pad_val1 !== 1'b0) begin errors++; $display("FAIL b2b_consumed%0d: got %b want 0", i, pad_val1); end
    end
    pad_rdy = 1'b0;
  endtask

  initial begin
    test_model();
    test_reset();
    test_zero_vector();
    test_fips_vector();
    test_reset_mid_busy();
    test_handshake_stress();
    test_input_change();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
